// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared widths and FSM state type for the processor/host RAM arbiter.
// Contents:
//   ADDR_W, BE_W, DATA_W - RAM word address, byte-enable and data widths
//   arb_state_t          - host-side FSM state (IDLE, RD_PEND)
package mem_arb_pkg;

  localparam int ADDR_W = 14;
  localparam int BE_W   = 32;
  localparam int DATA_W = 256;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_PEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe
// Shift register that follows a host read through the RAM read pipeline.
// A tag enters on the accept cycle and reaches the output on the cycle
// the RAM presents that read's data on ram_q.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset, clears all stages
//   i_tag  - high on the cycle a host read is issued to the RAM
//   o_tag  - high on the cycle ram_q carries the host read data
module rd_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tag,
  output logic o_tag
);

  logic [DEPTH-1:0] r_tags;

  // One stage per cycle of RAM read latency; a loop keeps DEPTH=1 legal.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tags <= '0;
    end else begin
      r_tags[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_tags[i] <= r_tags[i-1];
      end
    end
  end

  assign o_tag = r_tags[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares a single-port RAM between a processor datapath (absolute priority,
// never stalled, zero added latency) and a host/loader port using a
// valid/ready handshake. Host reads return through a registered h_rdata
// with a one-cycle h_rvalid pulse at accept + RD_LAT + 1.
// Build option:
//   MEM_ARB_HOST_WR_EN - when defined, host writes reach the RAM; when
//                        undefined the host port is read-only and a host
//                        write is accepted, dropped, and flags err.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   p_address/p_byteena/p_writedata     - processor request payload
//   p_rden/p_wren                       - processor single-cycle strobes
//   p_readdata                          - processor read data (= ram_q)
//   h_valid/h_ready/h_we                - host handshake and direction
//   h_address/h_byteena/h_wdata         - host request payload
//   h_rvalid/h_rdata                    - host read return
//   ram_address/ram_byteena/ram_data    - RAM request payload
//   ram_rden/ram_wren/ram_q             - RAM strobes and read data
//   err                                 - sticky protocol-error flag
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] p_address,
  input  logic [BE_W-1:0]   p_byteena,
  input  logic [DATA_W-1:0] p_writedata,
  input  logic              p_rden,
  input  logic              p_wren,
  output logic [DATA_W-1:0] p_readdata,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_address,
  input  logic [BE_W-1:0]   h_byteena,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteena,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              err
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [ADDR_W-1:0] r_ram_address;
  logic [BE_W-1:0]   r_ram_byteena;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_h_rvalid;
  logic [DATA_W-1:0] r_h_rdata;
  logic              r_err;

  logic w_p_active;
  logic w_h_accept;
  logic w_h_rd_accept;
  logic w_h_wr_issue;
  logic w_h_wr_err;
  logic w_tag_out;

  assign w_p_active    = p_rden | p_wren;
  assign h_ready       = (r_state == IDLE) && !reset && !w_p_active;
  assign w_h_accept    = h_valid & h_ready;
  assign w_h_rd_accept = w_h_accept & ~h_we;

`ifdef MEM_ARB_HOST_WR_EN
  assign w_h_wr_issue = w_h_accept & h_we;
  assign w_h_wr_err   = 1'b0;
`else
  // Read-only host port: the handshake still completes so the host never
  // hangs, but the write is dropped and reported through err.
  assign w_h_wr_issue = 1'b0;
  assign w_h_wr_err   = w_h_accept & h_we;
`endif

  // RAM request mux. The processor wins outright; when nobody drives the
  // RAM the payload holds its last driven value with both strobes low.
  // A simultaneous processor read and write issues only the write.
  always_comb begin
    ram_address = r_ram_address;
    ram_byteena = r_ram_byteena;
    ram_data    = r_ram_data;
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    if (w_p_active) begin
      ram_address = p_address;
      ram_byteena = p_byteena;
      ram_data    = p_writedata;
      ram_wren    = p_wren;
      ram_rden    = p_rden & ~p_wren;
    end else if (w_h_accept) begin
      ram_address = h_address;
      ram_byteena = h_byteena;
      ram_data    = h_wdata;
      ram_rden    = w_h_rd_accept;
      ram_wren    = w_h_wr_issue;
    end
  end

  // Remember whatever payload was last presented so idle cycles hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_address <= '0;
      r_ram_byteena <= '0;
      r_ram_data    <= '0;
    end else if (w_p_active || w_h_accept) begin
      r_ram_address <= ram_address;
      r_ram_byteena <= ram_byteena;
      r_ram_data    <= ram_data;
    end
  end

  // Host FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Only one host read is outstanding; the FSM returns to IDLE on the
  // edge that ends the h_rvalid pulse.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_h_rd_accept) w_next_state = RD_PEND;
      RD_PEND: if (r_h_rvalid)    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_h_rd_accept),
    .o_tag (w_tag_out)
  );

  // The tag, not the FSM, selects the capture cycle, so processor traffic
  // sharing ram_q on other cycles cannot leak into h_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_rvalid <= 1'b0;
      r_h_rdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_h_rvalid <= w_tag_out;
      if (w_tag_out) begin
        r_h_rdata <= ram_q;
      end
      if ((p_rden && p_wren) || w_h_wr_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign p_readdata = ram_q;
  assign h_rvalid   = r_h_rvalid;
  assign h_rdata    = r_h_rdata;
  assign err        = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter with a behavioural single-port RAM of
// RD_LAT read latency. Host reads are tracked by a scoreboard queue holding
// the expected data and return cycle; the queue is checked every cycle.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int RD_LAT = 2;
`ifdef MEM_ARB_HOST_WR_EN
  localparam bit HOST_WR = 1'b1;
`else
  localparam bit HOST_WR = 1'b0;
`endif

  localparam logic [DATA_W-1:0] PAT10 = {32{8'hA5}};
  localparam logic [DATA_W-1:0] PAT20 = {8{32'hC0DE0020}};
  localparam logic [DATA_W-1:0] PAT30 = {8{32'h3030BEEF}};
  localparam logic [DATA_W-1:0] PAT40 = {32{8'h11}};
  localparam logic [DATA_W-1:0] WR40  = {{28{8'hCC}}, 32'hDEADBEEF};
  localparam logic [DATA_W-1:0] NEW40 = {{28{8'h11}}, 32'hDEADBEEF};
  localparam logic [DATA_W-1:0] PAT50 = {16{16'h5A50}};
  localparam logic [DATA_W-1:0] OLD60 = {32{8'h06}};
  localparam logic [DATA_W-1:0] PAT60 = {8{32'h60606060}};
  localparam logic [BE_W-1:0]   BE_ALL = '1;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] p_address;
  logic [BE_W-1:0]   p_byteena;
  logic [DATA_W-1:0] p_writedata;
  logic              p_rden, p_wren;
  logic [DATA_W-1:0] p_readdata;
  logic              h_valid, h_ready, h_we;
  logic [ADDR_W-1:0] h_address;
  logic [BE_W-1:0]   h_byteena;
  logic [DATA_W-1:0] h_wdata;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteena;
  logic [DATA_W-1:0] ram_data;
  logic              ram_rden, ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic              err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cycle;
  } exp_t;
  exp_t expQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .p_address   (p_address),
    .p_byteena   (p_byteena),
    .p_writedata (p_writedata),
    .p_rden      (p_rden),
    .p_wren      (p_wren),
    .p_readdata  (p_readdata),
    .h_valid     (h_valid),
    .h_ready     (h_ready),
    .h_we        (h_we),
    .h_address   (h_address),
    .h_byteena   (h_byteena),
    .h_wdata     (h_wdata),
    .h_rvalid    (h_rvalid),
    .h_rdata     (h_rdata),
    .ram_address (ram_address),
    .ram_byteena (ram_byteena),
    .ram_data    (ram_data),
    .ram_rden    (ram_rden),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .err         (err)
  );

  // Behavioural RAM: byte-enabled write, reads return after RD_LAT edges.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] qPipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < BE_W; b++) begin
        if (ram_byteena[b]) mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
      end
    end
    if (ram_rden) qPipe[0] <= mem[ram_address];
    for (int s = 1; s < RD_LAT; s++) qPipe[s] <= qPipe[s-1];
  end
  assign ram_q = qPipe[RD_LAT-1];

  // Advance to the next falling edge and check any host read return
  // against the head of the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (h_rvalid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL h_rvalid_unexpected: got h_rvalid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = expQ.pop_front();
        if (h_rdata !== e.data || cyc != e.cycle) begin
          errors++;
          $display("[TB] FAIL host_read_return: got data=%h cycle=%0d, required data=%h cycle=%0d",
                   h_rdata, cyc, e.data, e.cycle);
        end
      end
    end
  endtask

  task automatic idleInputs();
    p_address = '0; p_byteena = '0; p_writedata = '0; p_rden = 1'b0; p_wren = 1'b0;
    h_valid = 1'b0; h_we = 1'b0; h_address = '0; h_byteena = '0; h_wdata = '0;
  endtask

  task automatic nextCycle();
    tick();
    idleInputs();
  endtask

  task automatic proc_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    nextCycle();
    p_wren = 1'b1; p_address = addr; p_writedata = data; p_byteena = BE_ALL;
  endtask

  task automatic do_reset();
    nextCycle();
    reset = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  // Present a host request until accepted (bounded); reads are pushed to
  // the scoreboard when doPush is set. Returns with the accept cycle still
  // current so the caller can inspect the RAM drive.
  task automatic host_req(input logic [ADDR_W-1:0] addr, input logic we,
                          input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wdata,
                          input logic [DATA_W-1:0] expData, input bit doPush,
                          output int acceptCyc);
    bit done = 1'b0;
    acceptCyc = -1;
    for (int n = 0; n < 20 && !done; n++) begin
      nextCycle();
      h_valid = 1'b1; h_we = we; h_address = addr; h_byteena = be; h_wdata = wdata;
      #1;
      if (h_ready === 1'b1) begin
        done = 1'b1;
        acceptCyc = cyc;
        if (!we && doPush) expQ.push_back('{expData, cyc + RD_LAT + 1});
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL host_accept_timeout: got h_ready=0 for 20 cycles at addr %h, required 1", addr);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 20 && expQ.size() != 0; n++) nextCycle();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL host_read_timeout: got %0d returns outstanding, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      #1;
      checks++;
      if (h_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ready_in_reset: got %b, required 0", h_ready);
      end
    end
    nextCycle();
    reset = 1'b0;
    #1;
    checks++;
    if (h_ready !== 1'b1 || h_rvalid !== 1'b0 || h_rdata !== '0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ready=%b rvalid=%b rdata=%h err=%b, required 1 0 0 0",
               h_ready, h_rvalid, h_rdata, err);
    end
    checks++;
    if (ram_address !== '0 || ram_byteena !== '0 || ram_data !== '0 ||
        ram_rden !== 1'b0 || ram_wren !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ram_drive: got addr=%h be=%h rden=%b wren=%b, required all zero",
               ram_address, ram_byteena, ram_rden, ram_wren);
    end
  endtask

  task automatic test_proc_read();
    proc_write(14'h0010, PAT10);
    nextCycle();
    p_rden = 1'b1; p_address = 14'h0010;
    #1;
    checks++;
    if (ram_rden !== 1'b1 || ram_wren !== 1'b0 || ram_address !== 14'h0010 || h_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL proc_read_issue: got rden=%b wren=%b addr=%h ready=%b, required 1 0 0010 0",
               ram_rden, ram_wren, ram_address, h_ready);
    end
    for (int i = 0; i < RD_LAT; i++) nextCycle();
    #1;
    checks++;
    if (p_readdata !== PAT10) begin
      errors++;
      $display("[TB] FAIL proc_read_data: got %h, required %h", p_readdata, PAT10);
    end
    checks++;
    if (ram_rden !== 1'b0 || ram_wren !== 1'b0 || ram_address !== 14'h0010) begin
      errors++;
      $display("[TB] FAIL idle_hold: got rden=%b wren=%b addr=%h, required 0 0 0010",
               ram_rden, ram_wren, ram_address);
    end
  endtask

  task automatic test_host_read_blocked();
    proc_write(14'h0020, PAT20);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      p_rden = 1'b1; p_address = 14'h0100;
      h_valid = 1'b1; h_address = 14'h0020;
      #1;
      checks++;
      if (h_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ready_blocked_%0d: got %b, required 0", i, h_ready);
      end
    end
    nextCycle();
    h_valid = 1'b1; h_address = 14'h0020;
    #1;
    expQ.push_back('{PAT20, cyc + RD_LAT + 1});
    checks++;
    if (h_ready !== 1'b1 || ram_rden !== 1'b1 || ram_address !== 14'h0020) begin
      errors++;
      $display("[TB] FAIL host_accept_drive: got ready=%b rden=%b addr=%h, required 1 1 0020",
               h_ready, ram_rden, ram_address);
    end
    nextCycle();
    #1;
    checks++;
    if (h_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_rd_pend: got %b, required 0", h_ready);
    end
    wait_drain();
    nextCycle();
    #1;
    checks++;
    if (h_ready !== 1'b1 || h_rdata !== PAT20) begin
      errors++;
      $display("[TB] FAIL after_return: got ready=%b rdata=%h, required 1 %h", h_ready, h_rdata, PAT20);
    end
  endtask

  task automatic test_inflight_proc();
    int acc;
    proc_write(14'h0030, PAT30);
    host_req(14'h0020, 1'b0, BE_ALL, '0, PAT20, 1'b1, acc);
    nextCycle();
    p_rden = 1'b1; p_address = 14'h0030;
    nextCycle();
    p_rden = 1'b1; p_address = 14'h0010;
    for (int i = 1; i < RD_LAT; i++) nextCycle();
    #1;
    checks++;
    if (p_readdata !== PAT30) begin
      errors++;
      $display("[TB] FAIL inflight_proc_data: got %h, required %h", p_readdata, PAT30);
    end
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      p_rden = 1'b1; p_address = 14'h0030;
    end
    #1;
    checks++;
    if (h_rdata !== PAT20) begin
      errors++;
      $display("[TB] FAIL rdata_hold: got %h, required %h", h_rdata, PAT20);
    end
  endtask

  task automatic test_host_write();
    int acc;
    proc_write(14'h0040, PAT40);
    host_req(14'h0040, 1'b1, 32'h0000000F, WR40, '0, 1'b0, acc);
    checks++;
    if (ram_wren !== HOST_WR || ram_rden !== 1'b0) begin
      errors++;
      $display("[TB] FAIL host_write_issue: got wren=%b rden=%b, required %b 0", ram_wren, ram_rden, HOST_WR);
    end
    nextCycle();
    #1;
    checks++;
    if (err !== !HOST_WR) begin
      errors++;
      $display("[TB] FAIL host_write_err: got %b, required %b", err, !HOST_WR);
    end
    host_req(14'h0040, 1'b0, BE_ALL, '0, HOST_WR ? NEW40 : PAT40, 1'b1, acc);
    wait_drain();
    do_reset();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_reset_clear: got %b, required 0", err);
    end
  endtask

  task automatic test_both_strobes();
    nextCycle();
    p_rden = 1'b1; p_wren = 1'b1; p_address = 14'h0050; p_writedata = PAT50; p_byteena = BE_ALL;
    #1;
    checks++;
    if (ram_wren !== 1'b1 || ram_rden !== 1'b0 || ram_address !== 14'h0050) begin
      errors++;
      $display("[TB] FAIL both_strobes_issue: got wren=%b rden=%b addr=%h, required 1 0 0050",
               ram_wren, ram_rden, ram_address);
    end
    for (int i = 0; i < 5; i++) nextCycle();
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: got %b, required 1", err);
    end
    nextCycle();
    p_rden = 1'b1; p_address = 14'h0050;
    for (int i = 0; i < RD_LAT; i++) nextCycle();
    #1;
    checks++;
    if (p_readdata !== PAT50) begin
      errors++;
      $display("[TB] FAIL both_strobes_write: got %h, required %h", p_readdata, PAT50);
    end
    do_reset();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: got %b, required 0", err);
    end
  endtask

  task automatic test_reset_inflight();
    int acc;
    host_req(14'h0020, 1'b0, BE_ALL, '0, '0, 1'b0, acc);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checks++;
    if (h_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b, required 1", h_ready);
    end
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      checks++;
      if (h_rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL dropped_read_%0d: got h_rvalid=%b, required 0", i, h_rvalid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    proc_write(14'h0060, OLD60);
    host_req(14'h0020, 1'b0, BE_ALL, '0, PAT20, 1'b1, acc1);
    host_req(14'h0030, 1'b0, BE_ALL, '0, PAT30, 1'b1, acc2);
    checks++;
    if (acc2 - acc1 != RD_LAT + 2) begin
      errors++;
      $display("[TB] FAIL read_read_spacing: got %0d, required %0d", acc2 - acc1, RD_LAT + 2);
    end
    wait_drain();
    host_req(14'h0060, 1'b1, BE_ALL, PAT60, '0, 1'b0, acc1);
    host_req(14'h0060, 1'b0, BE_ALL, '0, HOST_WR ? PAT60 : OLD60, 1'b1, acc2);
    checks++;
    if (acc2 - acc1 != 1) begin
      errors++;
      $display("[TB] FAIL write_read_spacing: got %0d, required 1", acc2 - acc1);
    end
    wait_drain();
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    test_reset();
    test_proc_read();
    test_host_read_blocked();
    test_inflight_proc();
    test_host_write();
    test_both_strobes();
    test_reset_inflight();
    test_back_to_back();
    for (int i = 0; i < 4; i++) nextCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 2, SHALL be the RAM read latency in cycles, legal range 1..3.
REQ-002 Port clk  in  1  single clock; all state on rising edge.
REQ-003 Port reset  in  1  synchronous, active-high reset.
REQ-004 Ports p_address  in  14, p_byteena  in  32, p_writedata  in  256, p_rden  in  1, p_wren  in  1: processor datapath RAM request, single-cycle strobes, never stalled.
REQ-005 Port p_readdata  out  256: processor read data.
REQ-006 Ports h_valid  in  1, h_ready  out  1, h_we  in  1, h_address  in  14, h_byteena  in  32, h_wdata  in  256: host/loader request, valid/ready handshake.
REQ-007 Ports h_rvalid  out  1, h_rdata  out  256: host read return.
REQ-008 Ports ram_address  out  14, ram_byteena  out  32, ram_data  out  256, ram_rden  out  1, ram_wren  out  1, ram_q  in  256: single-port RAM.
REQ-009 Port err  out  1: sticky protocol-error flag.

Function
REQ-010 Processor SHALL have absolute priority; any cycle with p_rden|p_wren drives RAM from p_* combinationally, zero added latency.
REQ-011 p_readdata SHALL equal ram_q combinationally; processor read timing is identical to a direct RAM connection.
REQ-012 p_rden and p_wren both high: write issued, read suppressed, err set.
REQ-013 h_ready SHALL be high only when state==IDLE, reset deasserted, p_rden==0 and p_wren==0.
REQ-014 Host request accepted on h_valid&h_ready; RAM driven from h_* that same cycle.
REQ-015 FSM states IDLE, RD_PEND. IDLE->RD_PEND on accepted host read; RD_PEND->IDLE the cycle after h_rvalid pulses; accepted host write stays in IDLE.
REQ-016 Tag pipeline, RD_LAT deep, SHALL mark the cycle ram_q carries the host read; h_rdata registered from ram_q on that cycle, h_rvalid a one-cycle pulse at accept+RD_LAT+1.
REQ-017 h_rdata SHALL hold its value until the next host read return.
REQ-018 Processor accesses in cycles while a host read is in flight SHALL NOT corrupt h_rdata (tag selects the capture cycle).
REQ-019 RAM idle (no requester): ram_rden=ram_wren=0, address/byteena/data hold last driven values.
REQ-020 Host h_valid deasserted before acceptance is legal; payload only sampled at acceptance.

Reset
REQ-021 On reset: state=IDLE, tag pipeline cleared, h_rvalid=0, h_rdata=0, err=0, held RAM address/byteena/data=0.
REQ-022 Reset during RD_PEND SHALL drop the in-flight host read; no h_rvalid produced.

Configuration
REQ-023 Macro MEM_ARB_HOST_WR_EN defined: host writes (h_we=1) accepted and issued with h_byteena.
REQ-024 Macro undefined: host port read-only; h_we=1 request accepted (handshake completes), no RAM write, err set.

Structure
REQ-025 Package mem_arb_pkg SHALL hold ADDR_W=14, BE_W=32, DATA_W=256 and the FSM state enum.
REQ-026 One sub-module rd_tag_pipe (RD_LAT-deep shift register of host-read tags, synchronous reset).

Verification
REQ-027 Processor read addr 0x0010, RAM word preloaded 0xA5.. -> ram_rden same cycle, p_readdata=0xA5.. at RD_LAT.
REQ-028 Host read 0x0020 with p_rden high for 3 cycles -> h_ready low 3 cycles, accept cycle 4, h_rvalid at accept+3 (RD_LAT=2), h_rdata=RAM[0x0020].
REQ-029 Host read in flight, processor read of 0x0030 next cycle -> h_rdata=RAM[0x0020], p_readdata=RAM[0x0030], no mix-up.
REQ-030 Host write 0x0040, byteena=0x0000000F, data 0x..DEADBEEF -> with MEM_ARB_HOST_WR_EN low 4 bytes updated; without, RAM unchanged, err=1.
REQ-031 p_rden=p_wren=1 at 0x0050 -> only write issued, err=1 until reset.
REQ-032 Reset asserted one cycle after host read accept -> h_rvalid never pulses, state IDLE, h_ready high next idle cycle.
